threshold_sweep_ctrl: RTL and testbench
=======================================

# threshold_sweep_ctrl

Digital sequencer for the programmable-threshold voltage sensor. It drives the 8-way threshold-select lines (one-hot true and complement) that feed the analog comparator array, waits a programmable settling time per threshold, and samples the comparator output through a synchronizer. It supports a full 8-code sweep or a single-code measurement, and reports the results as a thermometer word, a level count and a monotonicity flag. It sits between the ui_in/uo_out pins and the analog macro's y_d/n_d select inputs.

## Interface
Parameters:
- SETTLE_CYCLES, default 16: settling cycles per threshold code before sampling; legal range 3..255.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  level-sampled start request; honoured only in IDLE.
- abort  input  1  cancels an active measurement.
- mode  input  1  0 = full sweep of codes 0..7; 1 = single code.
- code_in  input  3  code used in single mode; latched when start is accepted.
- cmp_in  input  1  raw comparator output from the analog macro (asynchronous); 1 = input above the selected threshold.
- sel_y  output  8  one-hot threshold select to the analog macro.
- sel_n  output  8  bitwise complement of sel_y.
- busy  output  1  high in SETTLE and SAMPLE.
- done  output  1  one-cycle pulse when results update.
- therm  output  8  per-code sample results; bit k = comparator result at code k.
- level  output  4  number of ones in therm, 0..8.
- nonmono  output  1  sweep result is not of the form 2^k-1.

## Operation
- cmp_in passes through a 2-flop synchronizer (cmp_s). The synchronizer is also cleared by reset.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE: sel_y=0, busy=0.
  - When start=1 and abort=0: latch mode and code_in, clear the working thermometer wt, set cur = (mode ? code_in : 0), load cnt = SETTLE_CYCLES-1, then go to SETTLE.
- SETTLE: sel_y = 1<<cur.
  - Decrement cnt each cycle.
  - When cnt==0, go to SAMPLE.
- SAMPLE: sel_y is held, and wt[cur] <= cmp_s.
  - If single mode, or cur==7: go to DONE.
  - Otherwise: cur <= cur+1, reload cnt, go to SETTLE.
- DONE: sel_y=0, done=1 for this single cycle. Next state is IDLE unconditionally.
- Result registers therm, level and nonmono load on the SAMPLE->DONE transition and hold until the next such load:
  - therm = wt including the final sample.
  - level = popcount(therm).
  - nonmono = (mode==0) && (therm != 2^level - 1).
  - nonmono is always 0 in single mode.
- sel_n is always ~sel_y, including during reset, so reset drives sel_n = 8'hFF.
- abort=1 in SETTLE or SAMPLE:
  - Next state is IDLE, with no done pulse.
  - therm, level and nonmono keep their previous values; wt is discarded.
  - abort has priority over the SAMPLE capture and over the transition.
- abort in IDLE or DONE has no effect, except that abort=1 blocks start acceptance in IDLE.
- start while busy or in DONE is ignored; it is not queued.
- Changes to code_in or mode after acceptance have no effect on the current run.

## Timing
- Reset values, applied asynchronously:
  - state=IDLE, sel_y=0, sel_n=8'hFF.
  - busy=0, done=0, therm=0, level=0, nonmono=0.
  - cnt=0, cur=0, synchronizer=0.
- Reset removal is synchronous to clk.
- Asserting rst_n low mid-run returns every output to its reset value immediately.
- Start accepted at edge E:
  - SETTLE occupies cycles E+1 .. E+SETTLE_CYCLES.
  - SAMPLE occurs in cycle E+SETTLE_CYCLES+1.
- Each code costs SETTLE_CYCLES+1 cycles.
- Full sweep: done is high in cycle E + 8*(SETTLE_CYCLES+1) + 1, which is cycle E+137 at the default.
- Single mode: done is high in cycle E + SETTLE_CYCLES + 2, which is cycle E+18 at the default.
- The earliest next start is accepted in the cycle after done, i.e. in IDLE.
- The sample seen in SAMPLE reflects cmp_in as it was 2 cycles earlier. It always reflects the current code, because SETTLE_CYCLES>=3.
- busy, done and sel_y are all registered outputs.

## Test plan
- Reset: hold rst_n=0 mid-sweep → sel_y=0, sel_n=FF, busy=0, therm=0 immediately; after release the block stays in IDLE until start.
- Full sweep with the comparator modelled as cmp=1 for codes <5 → therm=8'h1F, level=5, nonmono=0; done pulses exactly once, 137 cycles after start; sel_y steps 01,02,…,80.
- Non-monotonic sweep, cmp=1 only at codes 0, 1 and 3 → therm=8'h0B, level=3, nonmono=1.
- Single mode, code_in=6, cmp=1 → sel_y=8'h40 for 17 cycles, therm=8'h40, level=1, nonmono=0, done at E+18.
- Abort asserted at code 4 → IDLE next cycle, no done, sel_y=0; therm/level keep the prior run's values. A start asserted while busy is ignored.
- Synchronizer latency: toggle cmp_in 1 cycle before SAMPLE → old value captured; toggle it 3 cycles before SAMPLE → new value captured.

Source files
------------

// File: rtl/threshold_sweep_ctrl_if.sv
// Bus bundle between the pin-side controller logic and the threshold sweep
// sequencer: request/config inputs, comparator input, select lines and results.
interface threshold_sweep_ctrl_if;
   logic       start;
   logic       abort;
   logic       mode;
   logic [2:0] code_in;
   logic       cmp_in;
   logic [7:0] sel_y;
   logic [7:0] sel_n;
   logic       busy;
   logic       done;
   logic [7:0] therm;
   logic [3:0] level;
   logic       nonmono;

   modport master (
      output start, abort, mode, code_in, cmp_in,
      input  sel_y, sel_n, busy, done, therm, level, nonmono
   );

   modport slave (
      input  start, abort, mode, code_in, cmp_in,
      output sel_y, sel_n, busy, done, therm, level, nonmono
   );
endinterface

// File: rtl/threshold_sweep_ctrl.sv
// Threshold sweep sequencer: steps the one-hot threshold select through the
// requested codes, waits SETTLE_CYCLES per code, samples the synchronized
// comparator and publishes thermometer / level / monotonicity results.
module threshold_sweep_ctrl #(
   parameter int unsigned SETTLE_CYCLES = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   threshold_sweep_ctrl_if.slave bus
);

   typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

   localparam logic [7:0] CNT_LOAD = 8'(SETTLE_CYCLES - 1);

   state_t     state_reg, state_next;
   logic [7:0] cnt_reg, cnt_next;
   logic [2:0] cur_reg, cur_next;
   logic       mode_reg, mode_next;
   logic [7:0] wt_reg, wt_next;
   logic       load_results;

   logic       cmp_meta_reg, cmp_s_reg;

   logic [7:0] sel_y_reg, sel_y_next;
   logic       busy_reg, busy_next;
   logic       done_reg, done_next;
   logic [7:0] therm_reg;
   logic [3:0] level_reg;
   logic       nonmono_reg;

   logic [7:0] wt_final;
   logic [3:0] level_calc;
   logic [8:0] mono_mask;
   logic       nonmono_calc;

   // Working thermometer with the current sample merged in at position cur.
   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_wt_final
         assign wt_final[gi] = (cur_reg == 3'(gi)) ? cmp_s_reg : wt_reg[gi];
      end
   endgenerate

   // Result values computed from the completed thermometer word.
   always_comb begin
      level_calc = '0;
      for (int i = 0; i < 8; i++) begin
         level_calc = level_calc + {3'b000, wt_final[i]};
      end
      mono_mask    = (9'd1 << level_calc) - 9'd1;
      nonmono_calc = !mode_reg && ({1'b0, wt_final} != mono_mask);
   end

   // Two-flop synchronizer for the asynchronous comparator output.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmp_meta_reg <= 1'b0;
         cmp_s_reg    <= 1'b0;
      end else begin
         cmp_meta_reg <= bus.cmp_in;
         cmp_s_reg    <= cmp_meta_reg;
      end
   end

   // FSM state register plus its working datapath (counter, code, thermometer).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         cur_reg   <= '0;
         mode_reg  <= 1'b0;
         wt_reg    <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         cur_reg   <= cur_next;
         mode_reg  <= mode_next;
         wt_reg    <= wt_next;
      end
   end

   // Next-state logic; abort overrides both the sample capture and the advance.
   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      cur_next     = cur_reg;
      mode_next    = mode_reg;
      wt_next      = wt_reg;
      load_results = 1'b0;
      case (state_reg)
         IDLE: begin
            if (bus.start && !bus.abort) begin
               mode_next  = bus.mode;
               wt_next    = '0;
               cur_next   = bus.mode ? bus.code_in : 3'd0;
               cnt_next   = CNT_LOAD;
               state_next = SETTLE;
            end
         end
         SETTLE: begin
            if (bus.abort) begin
               state_next = IDLE;
            end else if (cnt_reg == 8'd0) begin
               state_next = SAMPLE;
            end else begin
               cnt_next = cnt_reg - 8'd1;
            end
         end
         SAMPLE: begin
            if (bus.abort) begin
               state_next = IDLE;
            end else begin
               wt_next = wt_final;
               if (mode_reg || (cur_reg == 3'd7)) begin
                  load_results = 1'b1;
                  state_next   = DONE;
               end else begin
                  cur_next   = cur_reg + 3'd1;
                  cnt_next   = CNT_LOAD;
                  state_next = SETTLE;
               end
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Registered outputs are decoded from the upcoming state so they line up with it.
   always_comb begin
      busy_next  = (state_next == SETTLE) || (state_next == SAMPLE);
      sel_y_next = busy_next ? (8'd1 << cur_next) : 8'd0;
      done_next  = (state_next == DONE);
   end

   // Output and result registers; results only change on a completed measurement.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel_y_reg   <= '0;
         busy_reg    <= 1'b0;
         done_reg    <= 1'b0;
         therm_reg   <= '0;
         level_reg   <= '0;
         nonmono_reg <= 1'b0;
      end else begin
         sel_y_reg <= sel_y_next;
         busy_reg  <= busy_next;
         done_reg  <= done_next;
         if (load_results) begin
            therm_reg   <= wt_final;
            level_reg   <= level_calc;
            nonmono_reg <= nonmono_calc;
         end
      end
   end

   assign bus.sel_y   = sel_y_reg;
   assign bus.sel_n   = ~sel_y_reg;
   assign bus.busy    = busy_reg;
   assign bus.done    = done_reg;
   assign bus.therm   = therm_reg;
   assign bus.level   = level_reg;
   assign bus.nonmono = nonmono_reg;

endmodule

// File: tb/tb_threshold_sweep_ctrl.sv
// Directed bench for threshold_sweep_ctrl: table of measurement vectors plus
// hand-written abort, reset and synchronizer-latency sequences.
module tb_threshold_sweep_ctrl;

   localparam int S   = 16;
   localparam int CPC = S + 1;

   logic clk;
   logic rst_n;
   threshold_sweep_ctrl_if bus_if();

   logic [7:0] cmp_pattern;
   logic       use_model;
   logic       cmp_manual;

   int checks;
   int failures;

   // Comparator model: high when the selected code is set in cmp_pattern.
   assign bus_if.cmp_in = use_model ? |(bus_if.sel_y & cmp_pattern) : cmp_manual;

   threshold_sweep_ctrl #(.SETTLE_CYCLES(S)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       mode;
      logic [2:0] code;
      logic [7:0] pattern;
      logic [7:0] therm;
      logic [3:0] level;
      logic       nonmono;
      int         lat;
   } vec_t;

   vec_t vecs[9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Present a start request for one edge; returns at the first negedge after acceptance.
   task automatic start_run(input logic m, input logic [2:0] c);
      @(negedge clk);
      bus_if.start   = 1'b1;
      bus_if.mode    = m;
      bus_if.code_in = c;
      @(negedge clk);
      bus_if.start   = 1'b0;
   endtask

   task automatic run_vec(input int i);
      int   lat;
      logic seq_ok;
      int   exp_code;
      lat    = 0;
      seq_ok = 1'b1;
      use_model   = 1'b1;
      cmp_pattern = vecs[i].pattern;
      start_run(vecs[i].mode, vecs[i].code);
      for (int k = 1; k <= 200; k++) begin
         if (bus_if.done === 1'b1) begin
            lat = k;
            break;
         end
         exp_code = vecs[i].mode ? int'(vecs[i].code) : (k - 1) / CPC;
         if (bus_if.busy !== 1'b1 || bus_if.sel_y !== (8'd1 << exp_code) ||
             bus_if.sel_n !== ~(8'd1 << exp_code))
            seq_ok = 1'b0;
         @(negedge clk);
      end
      chk("latency", lat, vecs[i].lat);
      chk("sel_seq", {31'd0, seq_ok}, 32'd1);
      chk("therm", {24'd0, bus_if.therm}, {24'd0, vecs[i].therm});
      chk("level", {28'd0, bus_if.level}, {28'd0, vecs[i].level});
      chk("nonmono", {31'd0, bus_if.nonmono}, {31'd0, vecs[i].nonmono});
      chk("done_idle_sel", {24'd0, bus_if.sel_y}, 32'd0);
      @(negedge clk);
      chk("done_one_cycle", {31'd0, bus_if.done}, 32'd0);
      $display("vec %0d mode=%0d code=%0d pat=%02h therm=%02h level=%0d nonmono=%0d lat=%0d",
               i, vecs[i].mode, vecs[i].code, vecs[i].pattern, bus_if.therm,
               bus_if.level, bus_if.nonmono, lat);
   endtask

   // Single-mode run with cmp_in raised on a chosen negedge after acceptance.
   task automatic sync_run(input int toggle_k, input logic [7:0] exp_therm, input string name);
      int lat;
      lat        = 0;
      use_model  = 1'b0;
      cmp_manual = 1'b0;
      start_run(1'b1, 3'd2);
      for (int k = 1; k <= 60; k++) begin
         if (k == toggle_k) cmp_manual = 1'b1;
         if (bus_if.done === 1'b1) begin
            lat = k;
            break;
         end
         @(negedge clk);
      end
      chk({name, "_lat"}, lat, 18);
      chk(name, {24'd0, bus_if.therm}, {24'd0, exp_therm});
      $display("sync toggle_k=%0d therm=%02h", toggle_k, bus_if.therm);
      cmp_manual = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   initial begin
      int done_seen;
      checks      = 0;
      failures    = 0;
      use_model   = 1'b1;
      cmp_pattern = 8'h00;
      cmp_manual  = 1'b0;
      bus_if.start   = 1'b0;
      bus_if.abort   = 1'b0;
      bus_if.mode    = 1'b0;
      bus_if.code_in = 3'd0;
      rst_n = 1'b0;

      vecs[0] = '{1'b0, 3'd0, 8'h1F, 8'h1F, 4'd5, 1'b0, 137};
      vecs[1] = '{1'b0, 3'd0, 8'h0B, 8'h0B, 4'd3, 1'b1, 137};
      vecs[2] = '{1'b1, 3'd6, 8'hFF, 8'h40, 4'd1, 1'b0, 18};
      vecs[3] = '{1'b0, 3'd0, 8'h00, 8'h00, 4'd0, 1'b0, 137};
      vecs[4] = '{1'b0, 3'd0, 8'hFF, 8'hFF, 4'd8, 1'b0, 137};
      vecs[5] = '{1'b1, 3'd0, 8'h00, 8'h00, 4'd0, 1'b0, 18};
      vecs[6] = '{1'b1, 3'd7, 8'h80, 8'h80, 4'd1, 1'b0, 18};
      vecs[7] = '{1'b0, 3'd0, 8'hFE, 8'hFE, 4'd7, 1'b1, 137};
      vecs[8] = '{1'b1, 3'd3, 8'h08, 8'h08, 4'd1, 1'b0, 18};

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_sel_y", {24'd0, bus_if.sel_y}, 32'd0);
      chk("rst_sel_n", {24'd0, bus_if.sel_n}, 32'hFF);
      chk("rst_busy", {31'd0, bus_if.busy}, 32'd0);
      chk("rst_done", {31'd0, bus_if.done}, 32'd0);
      chk("rst_therm", {24'd0, bus_if.therm}, 32'd0);
      chk("rst_level", {28'd0, bus_if.level}, 32'd0);
      chk("rst_nonmono", {31'd0, bus_if.nonmono}, 32'd0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("idle_after_rst", {31'd0, bus_if.busy}, 32'd0);

      for (int i = 0; i < 9; i++) run_vec(i);

      // Abort at code 4, with an ignored start while busy; prior results are therm=08 level=1
      use_model   = 1'b1;
      cmp_pattern = 8'hFF;
      start_run(1'b0, 3'd0);
      for (int k = 1; k < 76; k++) begin
         if (k == 40) begin
            bus_if.start   = 1'b1;
            bus_if.mode    = 1'b1;
            bus_if.code_in = 3'd7;
         end
         if (k == 43) bus_if.start = 1'b0;
         if (k == 45) chk("busy_start_ignored", {24'd0, bus_if.sel_y}, 32'h04);
         if (k == 75) begin
            chk("pre_abort_sel", {24'd0, bus_if.sel_y}, 32'h10);
            bus_if.abort = 1'b1;
         end
         @(negedge clk);
      end
      bus_if.abort = 1'b0;
      chk("abort_busy", {31'd0, bus_if.busy}, 32'd0);
      chk("abort_sel_y", {24'd0, bus_if.sel_y}, 32'd0);
      chk("abort_sel_n", {24'd0, bus_if.sel_n}, 32'hFF);
      done_seen = 0;
      for (int k = 0; k < 10; k++) begin
         if (bus_if.done === 1'b1) done_seen++;
         @(negedge clk);
      end
      chk("abort_no_done", done_seen, 0);
      chk("abort_therm_kept", {24'd0, bus_if.therm}, 32'h08);
      chk("abort_level_kept", {28'd0, bus_if.level}, 32'd1);
      $display("abort at code 4: busy=%0d therm=%02h level=%0d", bus_if.busy, bus_if.therm, bus_if.level);

      // Synchronizer latency
      sync_run(16, 8'h00, "sync_late_toggle");
      sync_run(14, 8'h04, "sync_early_toggle");

      // Reset asserted mid-sweep
      use_model   = 1'b1;
      cmp_pattern = 8'hFF;
      start_run(1'b0, 3'd0);
      repeat (50) @(negedge clk);
      chk("pre_rst_busy", {31'd0, bus_if.busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("midrst_sel_y", {24'd0, bus_if.sel_y}, 32'd0);
      chk("midrst_sel_n", {24'd0, bus_if.sel_n}, 32'hFF);
      chk("midrst_busy", {31'd0, bus_if.busy}, 32'd0);
      chk("midrst_therm", {24'd0, bus_if.therm}, 32'd0);
      chk("midrst_level", {28'd0, bus_if.level}, 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      chk("post_rst_idle_busy", {31'd0, bus_if.busy}, 32'd0);
      chk("post_rst_idle_sel", {24'd0, bus_if.sel_y}, 32'd0);
      $display("reset mid-sweep: sel_y=%02h sel_n=%02h busy=%0d", bus_if.sel_y, bus_if.sel_n, bus_if.busy);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
